cb_prefix_sequencer: RTL and testbench

- Executes the second byte of a CB-prefixed instruction: rotates/shifts, SWAP, BIT, RES and SET.
- Operand is either a register (B,C,D,E,H,L,A) or memory at (HL).
- Instantiates Logic_Unit and sequences operand fetch, the compute step, register/memory writeback and flag writeback.
- Sits between the main CPU control FSM (which fetches the 0xCB prefix and the opcode byte) and the register file / memory bus.

---
 rtl/cb_prefix_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_cb_prefix_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cb_prefix_sequencer.sv
// cb_prefix_sequencer: executes the second byte of a CB-prefixed instruction
// (rotate/shift/SWAP, BIT, RES, SET) on a register or on memory at (HL).
//
// Logic_Unit ports:
//   i_Opcode[5:0]   {reserved, class[1:0], sub-op/bit index[2:0]}
//   i_Operand[7:0]  value to operate on
//   i_F[3:0]        incoming flags {Z,N,H,C}
//   i_Z_Disable     keep the incoming Z flag instead of computing it
//   o_Result[7:0]   result data
//   o_F[3:0]        result flags {Z,N,H,C}
//
// cb_prefix_sequencer ports:
//   i_Clk, i_Reset             clock, asynchronous active-high reset
//   i_Start, i_Opcode, i_HL    start request with opcode and HL (sampled in IDLE)
//   i_F                        current flags {Z,N,H,C}
//   i_Reg_Data, o_Reg_Sel      combinational register read port
//   o_Reg_WE, o_Reg_WData      register write port
//   o_F_WE, o_F                flag write port
//   o_Mem_*, i_Mem_*           single-transfer memory bus, req held until ack
//   o_Busy, o_Done, o_Error    status; Done/Error are one-cycle pulses

module Logic_Unit (
    input  logic [5:0] i_Opcode,
    input  logic [7:0] i_Operand,
    input  logic [3:0] i_F,
    input  logic       i_Z_Disable,
    output logic [7:0] o_Result,
    output logic [3:0] o_F
);
    logic [7:0] a;
    logic [7:0] sh;
    logic [7:0] mask;
    logic       c;
    always_comb begin
        a    = i_Operand;
        mask = 8'd1 << i_Opcode[2:0];
        case (i_Opcode[2:0])
            3'd0:    begin sh = {a[6:0], a[7]};   c = a[7]; end
            3'd1:    begin sh = {a[0], a[7:1]};   c = a[0]; end
            3'd2:    begin sh = {a[6:0], i_F[0]}; c = a[7]; end
            3'd3:    begin sh = {i_F[0], a[7:1]}; c = a[0]; end
            3'd4:    begin sh = {a[6:0], 1'b0};   c = a[7]; end
            3'd5:    begin sh = {a[7], a[7:1]};   c = a[0]; end
            3'd6:    begin sh = {a[3:0], a[7:4]}; c = 1'b0; end
            default: begin sh = {1'b0, a[7:1]};   c = a[0]; end
        endcase
        o_Result = a;
        o_F      = i_F;
        // opcode bit 5 set selects no operation (pass-through)
        if (!i_Opcode[5]) begin
            case (i_Opcode[4:3])
                2'b00: begin
                    o_Result = sh;
                    o_F      = {~|sh, 2'b00, c};
                end
                2'b01:   o_F      = {~|(a & mask), 2'b01, i_F[0]};
                2'b10:   o_Result = a & ~mask;
                default: o_Result = a | mask;
            endcase
        end
        if (i_Z_Disable) o_F[3] = i_F[3];
    end
endmodule

module cb_prefix_sequencer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic        i_Start,
    input  logic [7:0]  i_Opcode,
    input  logic [15:0] i_HL,
    input  logic [3:0]  i_F,
    input  logic [7:0]  i_Reg_Data,
    output logic [2:0]  o_Reg_Sel,
    output logic        o_Reg_WE,
    output logic [7:0]  o_Reg_WData,
    output logic        o_F_WE,
    output logic [3:0]  o_F,
    output logic        o_Mem_Req,
    output logic        o_Mem_Write,
    output logic [15:0] o_Mem_Addr,
    output logic [7:0]  o_Mem_WData,
    input  logic        i_Mem_Ack,
    input  logic [7:0]  i_Mem_RData,
    output logic        o_Busy,
    output logic        o_Done,
    output logic        o_Error
);
    typedef enum logic [2:0] {IDLE, EXEC_R, RD, EXEC_M, WR} state_t;

    state_t      state_q, state_d;
    logic [7:0]  op_q, op_d;
    logic [15:0] hl_q, hl_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  lu_r;
    logic [3:0]  lu_f;
    logic        is_bit, is_rs, timeout;

    Logic_Unit u_lu (
        .i_Opcode    ({1'b0, op_q[7:3]}),
        .i_Operand   (state_q == EXEC_M ? rdata_q : i_Reg_Data),
        .i_F         (i_F),
        .i_Z_Disable (1'b0),
        .o_Result    (lu_r),
        .o_F         (lu_f)
    );

    assign is_bit  = op_q[7:6] == 2'b01;
    assign is_rs   = op_q[7];
    // counter value equal to the limit means the limit of wait cycles has elapsed
    assign timeout = TIMEOUT_CYCLES != 0 && cnt_q == 8'(TIMEOUT_CYCLES);

    assign o_Reg_Sel   = op_q[2:0];
    assign o_Mem_Addr  = hl_q;
    assign o_Mem_WData = wdata_q;
    assign o_Busy      = state_q != IDLE;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        hl_d        = hl_q;
        rdata_d     = rdata_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        o_Reg_WE    = 1'b0;
        o_Reg_WData = 8'h00;
        o_F_WE      = 1'b0;
        o_F         = 4'h0;
        o_Mem_Req   = 1'b0;
        o_Mem_Write = 1'b0;
        o_Done      = 1'b0;
        o_Error     = 1'b0;
        case (state_q)
            IDLE: if (i_Start) begin
                op_d    = i_Opcode;
                hl_d    = i_HL;
                cnt_d   = 8'd0;
                state_d = i_Opcode[2:0] == 3'd6 ? RD : EXEC_R;
            end
            EXEC_R: begin
                o_Reg_WE    = !is_bit;
                o_Reg_WData = lu_r;
                o_F_WE      = !is_rs;
                o_F         = lu_f;
                o_Done      = 1'b1;
                state_d     = IDLE;
            end
            EXEC_M: begin
                o_F_WE  = !is_rs;
                o_F     = lu_f;
                wdata_d = lu_r;
                o_Done  = is_bit;
                cnt_d   = 8'd0;
                state_d = is_bit ? IDLE : WR;
            end
            RD, WR: begin
                // on timeout the request is dropped so a late ack cannot complete a write
                if (timeout) begin
                    o_Error = 1'b1;
                    state_d = IDLE;
                end else begin
                    o_Mem_Req   = 1'b1;
                    o_Mem_Write = state_q == WR;
                    if (i_Mem_Ack) begin
                        rdata_d = state_q == RD ? i_Mem_RData : rdata_q;
                        o_Done  = state_q == WR;
                        state_d = state_q == RD ? EXEC_M : IDLE;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= IDLE;
            op_q    <= 8'h00;
            hl_q    <= 16'h0000;
            rdata_q <= 8'h00;
            wdata_q <= 8'h00;
            cnt_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            hl_q    <= hl_d;
            rdata_q <= rdata_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_cb_prefix_sequencer.sv
// tb_cb_prefix_sequencer: directed self-checking bench for cb_prefix_sequencer
module tb_cb_prefix_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  opcode = 8'h00;
    logic [15:0] hl = 16'h0000;
    logic [3:0]  f_in = 4'h0;
    logic [7:0]  reg_data = 8'h00;
    logic        ack = 1'b0;
    logic [7:0]  rdata = 8'h00;
    logic [2:0]  reg_sel;
    logic        reg_we, f_we, mem_req, mem_write, busy, done, error;
    logic [7:0]  reg_wdata, mem_wdata;
    logic [3:0]  f_out;
    logic [15:0] mem_addr;
    int n_chk = 0, n_fail = 0;
    int n_wr = 0, n_done = 0, n_err = 0, n_rwe = 0;
    int b_wr, b_done, b_err, b_rwe;

    cb_prefix_sequencer #(.TIMEOUT_CYCLES(4)) dut (
        .i_Clk       (clk),
        .i_Reset     (rst),
        .i_Start     (start),
        .i_Opcode    (opcode),
        .i_HL        (hl),
        .i_F         (f_in),
        .i_Reg_Data  (reg_data),
        .o_Reg_Sel   (reg_sel),
        .o_Reg_WE    (reg_we),
        .o_Reg_WData (reg_wdata),
        .o_F_WE      (f_we),
        .o_F         (f_out),
        .o_Mem_Req   (mem_req),
        .o_Mem_Write (mem_write),
        .o_Mem_Addr  (mem_addr),
        .o_Mem_WData (mem_wdata),
        .i_Mem_Ack   (ack),
        .i_Mem_RData (rdata),
        .o_Busy      (busy),
        .o_Done      (done),
        .o_Error     (error)
    );

    always #5 clk = ~clk;

    // event counters sampled mid-cycle, where outputs depend only on settled state
    always @(negedge clk) begin
        if (mem_req && mem_write) n_wr <= n_wr + 1;
        if (done) n_done <= n_done + 1;
        if (error) n_err <= n_err + 1;
        if (reg_we) n_rwe <= n_rwe + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic snap;
        b_wr = n_wr; b_done = n_done; b_err = n_err; b_rwe = n_rwe;
    endtask

    initial begin
        // reset state
        tick; #1;
        chk("rst_busy", busy, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_sel", reg_sel, 0);
        rst = 1'b0;

        // SWAP A
        tick; start = 1; opcode = 8'h37; reg_data = 8'hF0; #1;
        chk("swap_idle", busy, 0);
        tick; start = 0; #1;
        chk("swap_sel", reg_sel, 7);
        chk("swap_we", reg_we, 1);
        chk("swap_wd", reg_wdata, 8'h0F);
        chk("swap_fwe", f_we, 1);
        chk("swap_f", f_out, 4'h0);
        chk("swap_done", done, 1);
        chk("swap_busy", busy, 1);
        tick; #1;
        chk("swap_end", busy, 0);

        // RLC (HL), zero-wait
        snap;
        tick; start = 1; opcode = 8'h06; hl = 16'hC000; f_in = 4'h0; #1;
        tick; start = 0; ack = 1; rdata = 8'h85; #1;
        chk("rlc_rreq", mem_req, 1);
        chk("rlc_rwr", mem_write, 0);
        chk("rlc_raddr", mem_addr, 16'hC000);
        chk("rlc_rdone", done, 0);
        tick; #1;
        chk("rlc_fwe", f_we, 1);
        chk("rlc_f", f_out, 4'h1);
        chk("rlc_xreq", mem_req, 0);
        tick; #1;
        chk("rlc_wreq", mem_req, 1);
        chk("rlc_wwr", mem_write, 1);
        chk("rlc_wdat", mem_wdata, 8'h0B);
        chk("rlc_waddr", mem_addr, 16'hC000);
        chk("rlc_done", done, 1);
        tick; ack = 0; #1;
        chk("rlc_end", busy, 0);
        chk("rlc_nwr", n_wr - b_wr, 1);
        chk("rlc_nrwe", n_rwe - b_rwe, 0);

        // BIT 7,(HL) with two wait cycles
        snap;
        tick; start = 1; opcode = 8'h7E; hl = 16'h1234; f_in = 4'h1; #1;
        tick; start = 0; rdata = 8'h00; #1;
        chk("bit_w1", mem_req, 1);
        tick; #1;
        chk("bit_w2", mem_req, 1);
        tick; ack = 1; #1;
        chk("bit_ack", mem_req, 1);
        chk("bit_ackdone", done, 0);
        tick; ack = 0; #1;
        chk("bit_fwe", f_we, 1);
        chk("bit_f", f_out, 4'hB);
        chk("bit_done", done, 1);
        tick; #1;
        chk("bit_end", busy, 0);
        chk("bit_nwr", n_wr - b_wr, 0);
        chk("bit_nrwe", n_rwe - b_rwe, 0);
        chk("bit_ndone", n_done - b_done, 1);
        f_in = 4'h0;

        // SET 0,B with start held while busy
        snap;
        tick; start = 1; opcode = 8'hC0; reg_data = 8'h00; #1;
        tick; #1;
        chk("set_sel", reg_sel, 0);
        chk("set_wd", reg_wdata, 8'h01);
        chk("set_we", reg_we, 1);
        chk("set_fwe", f_we, 0);
        chk("set_done", done, 1);
        tick; start = 0; #1;
        chk("set_end", busy, 0);
        tick; #1;
        chk("set_nrwe", n_rwe - b_rwe, 1);
        chk("set_ndone", n_done - b_done, 1);

        // RES 0,(HL) interrupted by asynchronous reset
        snap;
        tick; start = 1; opcode = 8'h86; hl = 16'h8000; ack = 0; #1;
        tick; start = 0; #1;
        chk("res_req", mem_req, 1);
        tick; #3; rst = 1; #1;
        chk("ares_req", mem_req, 0);
        chk("ares_busy", busy, 0);
        chk("ares_addr", mem_addr, 0);
        chk("ares_sel", reg_sel, 0);
        tick; rst = 0;
        tick; start = 1; opcode = 8'h37; reg_data = 8'hF0; #1;
        tick; start = 0; #1;
        chk("post_wd", reg_wdata, 8'h0F);
        chk("post_done", done, 1);
        tick; #1;
        chk("res_nwr", n_wr - b_wr, 0);

        // RL (HL) never acked: timeout
        snap;
        tick; start = 1; opcode = 8'h16; hl = 16'h4000; ack = 0; #1;
        tick; start = 0; #1;
        for (int i = 0; i < 4; i++) begin
            chk("to_wait_req", mem_req, 1);
            chk("to_wait_err", error, 0);
            tick; #1;
        end
        chk("to_err", error, 1);
        chk("to_err_req", mem_req, 0);
        tick; #1;
        chk("to_busy", busy, 0);
        chk("to_err_clr", error, 0);
        tick; #1;
        chk("to_nerr", n_err - b_err, 1);
        chk("to_ndone", n_done - b_done, 0);
        chk("to_nwr", n_wr - b_wr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
